// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card type, card range constants and deal state encoding
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_MIN   = 4'd1;
  localparam card_t CARD_MAX   = 4'd13;

  typedef enum logic [2:0] {
    P1,
    D1,
    P2,
    D2,
    P3,
    D3,
    DONE
  } deal_state_t;

  // Successor of a card value; anything at or above the top of the range wraps to the bottom.
  function automatic card_t next_card(card_t c);
    return (c >= CARD_MAX) ? CARD_MIN : c + 4'd1;
  endfunction

endpackage

// File: rtl/card_counter.sv
// rtl/card_counter.sv - free-running card value source cycling 1..13
module card_counter
  import card_pkg::*;
#(
  parameter card_t CTR_RESET = CARD_MIN
) (
  input  logic  clock,
  input  logic  reset,
  output card_t card_ctr
);

  // Advance one card every cycle; reset reloads the configured start value.
  always_ff @(posedge clock) begin
    if (reset) begin
      card_ctr <= CTR_RESET;
    end else begin
      card_ctr <= next_card(card_ctr);
    end
  end

endmodule

// File: rtl/card_deal.sv
// rtl/card_deal.sv - two-hand card dealer; define CARD_DEAL_CTR_OUT_EN to expose card_ctr_o
module card_deal
  import card_pkg::*;
#(
  parameter int CTR_RESET = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_round,
  input  logic       deal_req,
  input  logic       p_third,
  input  logic       d_third,
  output logic       deal_ack,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       round_done
`ifdef CARD_DEAL_CTR_OUT_EN
  ,
  output logic [3:0] card_ctr_o
`endif
);

  card_t       card_ctr;
  deal_state_t state;
  deal_state_t state_next;
  logic [2:0]  load_p;
  logic [2:0]  load_d;
  logic        deal;
  logic        take;
  card_t       p_slot [3];
  card_t       d_slot [3];

  card_counter #(
    .CTR_RESET(card_t'(CTR_RESET))
  ) u_card_counter (
    .clock    (clock),
    .reset    (reset),
    .card_ctr (card_ctr)
  );

  // A request is only honoured outside the ack cycle, so a held request deals every other cycle.
  assign take = deal_req && !deal_ack;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= P1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and slot-load decode; new_round overrides any deal in the same cycle.
  always_comb begin
    state_next = state;
    load_p     = 3'b000;
    load_d     = 3'b000;
    case (state)
      P1: if (take) begin load_p[0] = 1'b1; state_next = D1; end
      D1: if (take) begin load_d[0] = 1'b1; state_next = P2; end
      P2: if (take) begin load_p[1] = 1'b1; state_next = D2; end
      D2: if (take) begin load_d[1] = 1'b1; state_next = P3; end
      P3: begin
        if (!p_third) begin
          state_next = D3;
        end else if (take) begin
          load_p[2]  = 1'b1;
          state_next = D3;
        end
      end
      D3: begin
        if (!d_third) begin
          state_next = DONE;
        end else if (take) begin
          load_d[2]  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = P1;
    endcase
    if (new_round) begin
      state_next = P1;
      load_p     = 3'b000;
      load_d     = 3'b000;
    end
  end

  assign deal = (|load_p) || (|load_d);

  // Slots capture the current card on their own deal and clear on reset or a new round.
  always_ff @(posedge clock) begin
    if (reset || new_round) begin
      for (int i = 0; i < 3; i++) begin
        p_slot[i] <= CARD_EMPTY;
        d_slot[i] <= CARD_EMPTY;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load_p[i]) p_slot[i] <= card_ctr;
        if (load_d[i]) d_slot[i] <= card_ctr;
      end
    end
  end

  // Ack pulses for exactly the cycle after a card is loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      deal_ack <= 1'b0;
    end else begin
      deal_ack <= deal;
    end
  end

  assign pcard1     = p_slot[0];
  assign pcard2     = p_slot[1];
  assign pcard3     = p_slot[2];
  assign dcard1     = d_slot[0];
  assign dcard2     = d_slot[1];
  assign dcard3     = d_slot[2];
  assign round_done = (state == DONE);

`ifdef CARD_DEAL_CTR_OUT_EN
  assign card_ctr_o = card_ctr;
`endif

endmodule
